// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit:
// FSM state encoding, opcodes, ALUOp codes, mux selects and ALU operations.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMREAD = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECR   = 4'd6,
      ALUWB   = 4'd7,
      EXECI   = 4'd8,
      JAL     = 4'd9,
      BEQ     = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REGA  = 2'b10;

   localparam logic [1:0] SRCB_REGB = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   function automatic logic [1:0] imm_sel(input logic [6:0] opcode);
      case (opcode)
         OP_SW:   return IMM_S;
         OP_BEQ:  return IMM_B;
         OP_JAL:  return IMM_J;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps the FSM's ALUOp plus funct3/funct7b5 onto an ALU operation.
module aludec
   import mc_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [3:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alucontrol = funct7b5 ? ALU_SUB : ALU_ADD;
               3'b001:  alucontrol = ALU_SLL;
               3'b010:  alucontrol = ALU_SLT;
               3'b011:  alucontrol = ALU_SLTU;
               3'b100:  alucontrol = ALU_XOR;
               3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alucontrol = ALU_OR;
               default: alucontrol = ALU_AND;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences PC, IR, memory port, ALU and
// register file for lw, sw, R-type, I-type, beq and jal.
module multicycle_controller
   import mc_pkg::*;
#(
   parameter int STATE_W = 4
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         op,
   input  logic [2:0]         funct3,
   input  logic               funct7b5,
   input  logic               Zero,
   input  logic               MemReady,
   output logic               MemReq,
   output logic               MemWrite,
   output logic               AdrSrc,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               RegWrite,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ImmSrc,
   output logic [3:0]         ALUControl,
   output logic               IllegalInstr,
   output logic [STATE_W-1:0] State
);

   state_t     state_reg;
   state_t     state_next;
   logic [1:0] aluop;
   logic       branch;
   logic       pcupdate;
   logic       alu_f7b5;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= FETCH;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next   = FETCH;
      MemReq       = 1'b0;
      MemWrite     = 1'b0;
      AdrSrc       = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = SRCA_PC;
      ALUSrcB      = SRCB_REGB;
      ResultSrc    = RES_ALUOUT;
      ImmSrc       = imm_sel(op);
      IllegalInstr = 1'b0;
      aluop        = ALUOP_ADD;
      branch       = 1'b0;
      pcupdate     = 1'b0;

      case (state_reg)
         FETCH: begin
            MemReq     = 1'b1;
            ALUSrcA    = SRCA_PC;
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALURESULT;
            IRWrite    = MemReady;
            pcupdate   = MemReady;
            state_next = MemReady ? DECODE : FETCH;
         end
         DECODE: begin
            // Precompute the branch target into ALUOut while the opcode is decoded.
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_R:         state_next = EXECR;
               OP_I:         state_next = EXECI;
               OP_JAL:       state_next = JAL;
               OP_BEQ:       state_next = BEQ;
               default: begin
                  IllegalInstr = 1'b1;
                  state_next   = FETCH;
               end
            endcase
         end
         MEMADR: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_IMM;
            if (op == OP_LW)      state_next = MEMREAD;
            else if (op == OP_SW) state_next = MEMWR;
            else                  state_next = FETCH;
         end
         MEMREAD: begin
            MemReq     = 1'b1;
            AdrSrc     = 1'b1;
            ResultSrc  = RES_ALUOUT;
            state_next = MemReady ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            ResultSrc  = RES_DATA;
            RegWrite   = 1'b1;
            state_next = FETCH;
         end
         MEMWR: begin
            MemReq     = 1'b1;
            MemWrite   = 1'b1;
            AdrSrc     = 1'b1;
            ResultSrc  = RES_ALUOUT;
            state_next = MemReady ? FETCH : MEMWR;
         end
         EXECR: begin
            ALUSrcA    = SRCA_REGA;
            ALUSrcB    = SRCB_REGB;
            aluop      = ALUOP_FUNCT;
            state_next = ALUWB;
         end
         ALUWB: begin
            ResultSrc  = RES_ALUOUT;
            RegWrite   = 1'b1;
            state_next = FETCH;
         end
         EXECI: begin
            ALUSrcA    = SRCA_REGA;
            ALUSrcB    = SRCB_IMM;
            aluop      = ALUOP_FUNCT;
            state_next = ALUWB;
         end
         JAL: begin
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALUOUT;
            pcupdate   = 1'b1;
            state_next = ALUWB;
         end
         BEQ: begin
            ALUSrcA    = SRCA_REGA;
            ALUSrcB    = SRCB_REGB;
            aluop      = ALUOP_SUB;
            ResultSrc  = RES_ALUOUT;
            branch     = 1'b1;
            state_next = FETCH;
         end
         default: begin
            ImmSrc     = IMM_I;
            state_next = FETCH;
         end
      endcase

      PCWrite = (branch & Zero) | pcupdate;
   end

   // addi carries immediate bits in instr[30], so it must never select subtract.
   assign alu_f7b5 = funct7b5 & ~((op == OP_I) & (funct3 == 3'b000));

   aludec u_aludec (
      .aluop      (aluop),
      .funct3     (funct3),
      .funct7b5   (alu_f7b5),
      .alucontrol (ALUControl)
   );

   assign State = STATE_W'(state_reg);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: a per-instruction step-list model predicts every cycle's
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_multicycle_controller;
   import mc_pkg::*;

   localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BEQ = 5, K_ILL = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       MemReady;
   logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, IllegalInstr;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic [3:0] ALUControl;
   logic [3:0] State;

   int total = 0;
   int bad   = 0;
   logic [22:0] exp_q[$];

   int         cur_k;
   logic [6:0] cur_op;
   logic [2:0] cur_f3;
   logic       cur_f7;

   always #5 clk = ~clk;

   multicycle_controller #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite),
      .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .IllegalInstr(IllegalInstr), .State(State)
   );

   // Step list per instruction class: cycle i of the instruction visits this state.
   function automatic int seq_len(input int k);
      case (k)
         K_LW:    return 5;
         K_BEQ:   return 3;
         K_ILL:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic int seq_state(input int k, input int i);
      if (i == 0) return 0;
      if (i == 1) return 1;
      case (k)
         K_LW:    return (i == 2) ? 2 : ((i == 3) ? 3 : 4);
         K_SW:    return (i == 2) ? 2 : 5;
         K_R:     return (i == 2) ? 6 : 7;
         K_I:     return (i == 2) ? 8 : 7;
         K_JAL:   return (i == 2) ? 9 : 7;
         default: return 10;
      endcase
   endfunction

   function automatic bit is_wait(input int st);
      return (st == 0) || (st == 3) || (st == 5);
   endfunction

   function automatic logic [1:0] imm_of(input int k);
      case (k)
         K_SW:    return 2'b01;
         K_BEQ:   return 2'b10;
         K_JAL:   return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   // RISC-V funct semantics; sub only for R-type add/sub, sra for either class.
   function automatic logic [3:0] funct_alu(input int k, input logic [2:0] f3, input logic f7);
      case (f3)
         3'd0:    return (k == K_R && f7) ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return f7 ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic [22:0] expect_vec(input int st, input int k, input logic [2:0] f3,
                                              input logic f7, input logic mr, input logic z);
      logic req = 0, wr = 0, adr = 0, irw = 0, pcw = 0, rw = 0, ill = 0;
      logic [1:0] sa = 0, sb = 0, rs = 0;
      logic [3:0] alu = ALU_ADD;
      logic [3:0] s4 = st[3:0];
      case (st)
         0:  begin req = 1; sb = 2; rs = 2; irw = mr; pcw = mr; end
         1:  begin sa = 1; sb = 1; ill = (k == K_ILL); end
         2:  begin sa = 2; sb = 1; end
         3:  begin req = 1; adr = 1; end
         4:  begin rs = 1; rw = 1; end
         5:  begin req = 1; wr = 1; adr = 1; end
         6:  begin sa = 2; alu = funct_alu(k, f3, f7); end
         7:  begin rw = 1; end
         8:  begin sa = 2; sb = 1; alu = funct_alu(k, f3, f7); end
         9:  begin sa = 1; sb = 2; pcw = 1; end
         default: begin sa = 2; alu = ALU_SUB; pcw = z; end
      endcase
      return {s4, req, wr, adr, irw, pcw, rw, sa, sb, rs, imm_of(k), alu, ill};
   endfunction

   task automatic drive(input int st, input logic rst, input logic mr, input logic z);
      @(posedge clk);
      #1;
      reset    = rst;
      MemReady = mr;
      Zero     = z;
      op       = cur_op;
      funct3   = cur_f3;
      funct7b5 = cur_f7;
      exp_q.push_back(expect_vec(st, cur_k, cur_f3, cur_f7, mr, z));
   endtask

   function automatic bit legal_op(input logic [6:0] o);
      return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
             (o == OP_BEQ) || (o == OP_JAL);
   endfunction

   task automatic set_instr(input int k, input int f3, input int f7);
      logic [6:0] o;
      cur_k = k;
      case (k)
         K_LW:  cur_op = OP_LW;
         K_SW:  cur_op = OP_SW;
         K_R:   cur_op = OP_R;
         K_I:   cur_op = OP_I;
         K_JAL: cur_op = OP_JAL;
         K_BEQ: cur_op = OP_BEQ;
         default: begin
            o = 7'($urandom_range(0, 127));
            while (legal_op(o)) o = 7'($urandom_range(0, 127));
            cur_op = o;
         end
      endcase
      cur_f3 = (f3 < 0) ? 3'($urandom_range(0, 7)) : f3[2:0];
      cur_f7 = (f7 < 0) ? 1'($urandom_range(0, 1)) : f7[0];
   endtask

   // memwait < 0: random MemReady; otherwise each wait state stalls memwait cycles.
   task automatic run_instr(input int k, input int memwait, input int zmode,
                            input int f3, input int f7);
      int   idx = 0;
      int   waits = 0;
      int   st;
      logic mr, z;
      set_instr(k, f3, f7);
      while (idx < seq_len(k)) begin
         st = seq_state(k, idx);
         if (is_wait(st) && memwait >= 0) mr = (waits >= memwait);
         else                             mr = 1'($urandom_range(0, 1));
         z = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
         drive(st, 1'b0, mr, z);
         if (!is_wait(st) || mr) begin
            idx++;
            waits = 0;
         end else begin
            waits++;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endtask

   initial begin : monitor
      logic [22:0] want, got;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {State, MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                    ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, IllegalInstr};
            total++;
            if (got !== want) begin
               bad++;
               $display("FAIL outputs state=%0d got=%h want=%h at %0t",
                        want[22:19], got, want, $time);
            end else begin
               $display("cycle state=%0d op=%b mr=%b outputs=%h ok", want[22:19], op, MemReady, got);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      reset = 1'b1; MemReady = 1'b0; Zero = 1'b0;
      op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
      set_instr(K_LW, 0, 0);

      // Held in reset: FETCH outputs with MemReady low.
      drive(0, 1'b1, 1'b0, 1'b0);
      drive(0, 1'b1, 1'b0, 1'b0);

      run_instr(K_LW, 3, -1, -1, -1);   // FETCH stalls 3 cycles after reset release
      run_instr(K_LW, 0, -1, -1, -1);
      run_instr(K_SW, 2, -1, -1, -1);
      run_instr(K_BEQ, 0, 1, -1, -1);
      run_instr(K_BEQ, 0, 0, -1, -1);
      run_instr(K_R, 0, -1, 0, 1);
      run_instr(K_JAL, 0, -1, -1, -1);
      set_instr(K_ILL, -1, -1);
      cur_op = 7'b1111111;
      drive(0, 1'b0, 1'b1, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0);
      run_instr(K_I, 0, -1, 0, 1);

      // Reset asserted mid-wait in MEMREAD takes effect before the next edge.
      set_instr(K_LW, -1, -1);
      drive(0, 1'b0, 1'b1, 1'b0);
      drive(1, 1'b0, 1'b1, 1'b0);
      drive(2, 1'b0, 1'b1, 1'b0);
      drive(3, 1'b0, 1'b0, 1'b0);
      #5;
      reset = 1'b1;
      #1;
      chk("async_reset_state", 32'(State), 32'd0);
      chk("async_reset_regwrite", 32'(RegWrite), 32'd0);
      chk("async_reset_pcwrite", 32'(PCWrite), 32'd0);
      chk("async_reset_memreq", 32'(MemReq), 32'd1);
      drive(0, 1'b1, 1'b0, 1'b0);

      for (int n = 0; n < 150; n++) begin
         run_instr($urandom_range(K_LW, K_ILL), -1, -1, -1, -1);
      end

      @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
